// File: rtl/intr_ctrl.sv
// Interrupt controller feeding the core's intr[5:0] input.
// Five synchronised external lines plus the CP0 timer, each level- or
// rising-edge-sensitive, masked and registered onto intr. Software access is
// through a small register window on the core data bus.
module intr_ctrl #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_FF00,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ext_irq,
    input  logic        intimer,
    input  logic        memCe,
    input  logic        memWr,
    input  logic [31:0] memAddr,
    input  logic [31:0] wtData,
    output logic [31:0] rdData,
    output logic        hit,
    output logic [5:0]  intr
);

    localparam logic [2:0] OFF_PEND  = 3'd0;
    localparam logic [2:0] OFF_MASK  = 3'd1;
    localparam logic [2:0] OFF_EDGE  = 3'd2;
    localparam logic [2:0] OFF_CLEAR = 3'd3;
    localparam logic [2:0] OFF_RAW   = 3'd4;

    logic [4:0] sync_q [SYNC_STAGES];
    logic [5:0] raw;
    logic [5:0] prev;
    logic [5:0] rise;
    logic [5:0] pend;
    logic [5:0] pend_next;
    logic [5:0] mask;
    logic [5:0] edge_sel;
    logic [5:0] clr;
    logic [5:0] edge_chg;
    logic [2:0] off;
    logic       wr;
    logic       unused_bits;

    // Data bits above the register width and the byte lane bits are don't-care.
    assign unused_bits = ^{wtData[31:6], memAddr[1:0]};

    // Bus decode: the window is the 32-byte block at BASE_ADDR.
    assign hit = memCe && (memAddr[31:5] == BASE_ADDR[31:5]);
    assign off = memAddr[4:2];
    assign wr  = hit && memWr;

    // The timer is already in this clock domain, so it bypasses the synchroniser.
    assign raw  = {intimer, sync_q[SYNC_STAGES-1]};
    assign rise = raw & ~prev;

    assign clr      = (wr && off == OFF_CLEAR) ? wtData[5:0] : 6'h00;
    assign edge_chg = (wr && off == OFF_EDGE) ? (wtData[5:0] ^ edge_sel) : 6'h00;

    // A rise beats a clear in the same cycle; any bit switching mode is flushed.
    assign pend_next = ((edge_sel & (rise | (pend & ~clr))) | (~edge_sel & raw)) & ~edge_chg;

    // External request synchroniser chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= 5'h00;
        end else begin
            sync_q[0] <= ext_irq;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
        end
    end

    // Edge history, pending bits and the registered interrupt output.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev <= 6'h00;
            pend <= 6'h00;
            intr <= 6'h00;
        end else begin
            prev <= raw;
            pend <= pend_next;
            intr <= pend & mask;
        end
    end

    // Software-writable configuration registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            mask     <= 6'h00;
            edge_sel <= 6'h00;
        end else if (wr) begin
            if (off == OFF_MASK) mask     <= wtData[5:0];
            if (off == OFF_EDGE) edge_sel <= wtData[5:0];
        end
    end

    // Combinational read mux; zero outside the window and for unused offsets.
    always_comb begin
        rdData = 32'h0;
        if (hit) begin
            case (off)
                OFF_PEND: rdData = {26'h0, pend};
                OFF_MASK: rdData = {26'h0, mask};
                OFF_EDGE: rdData = {26'h0, edge_sel};
                OFF_RAW:  rdData = {26'h0, raw};
                default:  rdData = 32'h0;
            endcase
        end
    end

endmodule

// File: tb/tb_intr_ctrl.sv
// Self-checking bench for intr_ctrl: a register-access vector table plus
// hand-written latency and corner-case sequences.
module tb_intr_ctrl;

    localparam logic [31:0] B = 32'h0000_FF00;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  ext_irq;
    logic        intimer;
    logic        memCe;
    logic        memWr;
    logic [31:0] memAddr;
    logic [31:0] wtData;
    logic [31:0] rdData;
    logic        hit;
    logic [5:0]  intr;

    int checks = 0;
    int errors = 0;

    intr_ctrl #(.BASE_ADDR(B), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .ext_irq(ext_irq), .intimer(intimer),
        .memCe(memCe), .memWr(memWr), .memAddr(memAddr), .wtData(wtData),
        .rdData(rdData), .hit(hit), .intr(intr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic        ce;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_hit;
    } vec_t;

    vec_t vecs [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic rd(input logic ce, input logic [31:0] addr, output logic [31:0] d, output logic h);
        memCe   = ce;
        memWr   = 1'b0;
        memAddr = addr;
        #1;
        d = rdData;
        h = hit;
        memCe = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        logic        h;
        rd(1'b1, addr, d, h);
        chk(name, d, exp);
    endtask

    // Returns 1 time unit after the clock edge that performs the write.
    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        memCe   = 1'b1;
        memWr   = 1'b1;
        memAddr = addr;
        wtData  = data;
        @(posedge clk);
        #1;
        memCe = 1'b0;
        memWr = 1'b0;
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        logic        h;

        rst     = 1'b1;
        ext_irq = 5'h1F;
        intimer = 1'b0;
        memCe   = 1'b0;
        memWr   = 1'b0;
        memAddr = 32'h0;
        wtData  = 32'h0;

        //        we    ce    addr        wdata          exp_rd   exp_hit
        vecs[0]  = '{1'b1, 1'b1, B + 32'h04, 32'hFFFF_FFFF, 32'h0,  1'b1};
        vecs[1]  = '{1'b0, 1'b1, B + 32'h04, 32'h0,         32'h3F, 1'b1};
        vecs[2]  = '{1'b0, 1'b0, B + 32'h04, 32'h0,         32'h0,  1'b0};
        vecs[3]  = '{1'b1, 1'b1, B + 32'h08, 32'h0000_002A, 32'h0,  1'b1};
        vecs[4]  = '{1'b0, 1'b1, B + 32'h08, 32'h0,         32'h2A, 1'b1};
        vecs[5]  = '{1'b0, 1'b1, B + 32'h0B, 32'h0,         32'h2A, 1'b1};
        vecs[6]  = '{1'b0, 1'b1, B + 32'h14, 32'h0,         32'h0,  1'b1};
        vecs[7]  = '{1'b0, 1'b1, B + 32'h1C, 32'h0,         32'h0,  1'b1};
        vecs[8]  = '{1'b1, 1'b1, B + 32'h14, 32'h3F,        32'h0,  1'b1};
        vecs[9]  = '{1'b0, 1'b1, B + 32'h04, 32'h0,         32'h3F, 1'b1};
        vecs[10] = '{1'b0, 1'b1, B + 32'h20, 32'h0,         32'h0,  1'b0};
        vecs[11] = '{1'b0, 1'b1, B + 32'h0C, 32'h0,         32'h0,  1'b1};
        vecs[12] = '{1'b1, 1'b1, B + 32'h00, 32'h3F,        32'h0,  1'b1};
        vecs[13] = '{1'b0, 1'b1, B + 32'h00, 32'h0,         32'h0,  1'b1};
        vecs[14] = '{1'b1, 1'b1, B + 32'h07, 32'h0,         32'h0,  1'b1};
        vecs[15] = '{1'b0, 1'b1, 32'h0001_FF04, 32'h0,      32'h0,  1'b0};

        // Reset with all external lines high.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_intr", {26'h0, intr}, 32'h0);
        rd_chk("rst_mask", B + 32'h04, 32'h0);
        rd_chk("rst_edge", B + 32'h08, 32'h0);
        rd_chk("rst_pend", B + 32'h00, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        edge_step();
        rd_chk("rst_pend_e1", B, 32'h0);
        edge_step();
        rd_chk("rst_pend_e2", B, 32'h0);
        rd_chk("rst_raw_e2", B + 32'h10, 32'h1F);
        edge_step();
        rd_chk("rst_pend_e3", B, 32'h1F);
        chk("rst_intr_e3", {26'h0, intr}, 32'h0);

        // Register decode table with quiet inputs.
        ext_irq = 5'h00;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            if (vecs[i].we) begin
                wr(vecs[i].addr, vecs[i].wdata);
            end else begin
                rd(vecs[i].ce, vecs[i].addr, d, h);
                chk($sformatf("vec%0d_rd", i), d, vecs[i].exp_rd);
                chk($sformatf("vec%0d_hit", i), {31'h0, h}, {31'h0, vecs[i].exp_hit});
            end
        end
        rd_chk("mask_alias_wr", B + 32'h04, 32'h0);

        // Level mode on source 0.
        do_reset();
        wr(B + 32'h04, 32'h01);
        @(negedge clk);
        ext_irq[0] = 1'b1;
        edge_step();
        chk("lvl_intr_n", {26'h0, intr}, 32'h0);
        edge_step();
        chk("lvl_intr_n1", {26'h0, intr}, 32'h0);
        edge_step();
        chk("lvl_intr_n2", {26'h0, intr}, 32'h0);
        rd_chk("lvl_pend_n2", B, 32'h01);
        edge_step();
        chk("lvl_intr_n3", {26'h0, intr}, 32'h01);
        @(negedge clk);
        ext_irq[0] = 1'b0;
        repeat (3) edge_step();
        chk("lvl_drop_n2", {26'h0, intr}, 32'h01);
        edge_step();
        chk("lvl_drop_n3", {26'h0, intr}, 32'h0);

        // Edge mode: single-cycle pulse on source 1, then clear.
        do_reset();
        wr(B + 32'h08, 32'h02);
        wr(B + 32'h04, 32'h02);
        @(negedge clk);
        ext_irq[1] = 1'b1;
        @(negedge clk);
        ext_irq[1] = 1'b0;
        edge_step();
        chk("edge_intr_n1", {26'h0, intr}, 32'h0);
        edge_step();
        rd_chk("edge_pend_n2", B, 32'h02);
        chk("edge_intr_n2", {26'h0, intr}, 32'h0);
        edge_step();
        chk("edge_intr_n3", {26'h0, intr}, 32'h02);
        repeat (4) edge_step();
        chk("edge_intr_hold", {26'h0, intr}, 32'h02);
        wr(B + 32'h0C, 32'h02);
        rd_chk("edge_pend_clr", B, 32'h0);
        chk("edge_intr_clr0", {26'h0, intr}, 32'h02);
        edge_step();
        chk("edge_intr_clr1", {26'h0, intr}, 32'h0);

        // Rise and clear in the same cycle, then a mode change flushes the bit.
        do_reset();
        wr(B + 32'h08, 32'h08);
        wr(B + 32'h04, 32'h08);
        @(negedge clk);
        ext_irq[3] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        wr(B + 32'h0C, 32'h08);
        rd_chk("sim_set_wins", B, 32'h08);
        wr(B + 32'h08, 32'h00);
        rd_chk("edge_chg_flush", B, 32'h0);
        edge_step();
        rd_chk("edge_chg_resume", B, 32'h08);
        ext_irq = 5'h00;

        // Timer source bypasses the synchroniser.
        do_reset();
        wr(B + 32'h04, 32'h20);
        @(negedge clk);
        intimer = 1'b1;
        edge_step();
        rd_chk("tmr_pend_n", B, 32'h20);
        chk("tmr_intr_n", {26'h0, intr}, 32'h0);
        edge_step();
        chk("tmr_intr_n1", {26'h0, intr}, 32'h20);
        edge_step();
        chk("tmr_intr_n2", {26'h0, intr}, 32'h20);
        wr(B + 32'h04, 32'h00);
        chk("tmr_mask_m", {26'h0, intr}, 32'h20);
        edge_step();
        chk("tmr_mask_m1", {26'h0, intr}, 32'h0);

        // Mid-operation reset with the timer still asserted.
        wr(B + 32'h04, 32'h20);
        edge_step();
        chk("mid_pre_intr", {26'h0, intr}, 32'h20);
        @(negedge clk);
        rst = 1'b1;
        edge_step();
        chk("mid_rst_intr", {26'h0, intr}, 32'h0);
        rd_chk("mid_rst_mask", B + 32'h04, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        intimer = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
